// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR read arbiter: FSM encoding and width helpers.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    function automatic int ch_idx_w(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

    function automatic int tmo_cnt_w(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ddr_rd_arbiter_rr_pick.sv
// Round-robin picker: lowest requester strictly after ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is consumed.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         vld,
    output logic [W-1:0] winner
);

    localparam logic [W:0] N_W = (W+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W:0]     base;
    logic [W-1:0]   off;
    logic [W:0]     sum;

    always_comb begin
        dbl  = {req, req};
        base = {1'b0, ptr} + {{W{1'b0}}, 1'b1};
        // base never exceeds N, so the window always stays inside the doubled vector
        rot  = dbl[base +: N];
        off  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = W'(i);
            end
        end
        sum = base + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        winner = sum[W-1:0];
        vld    = |req;
    end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Grants one DDR read port to CH_NUM readers, whole bursts, round-robin.
// Latency: ch_rreq at t gives ddr_rreq at t+1; data/done steering is combinational.
// Backpressure: ddr_rreq held until ddr_rrdy; grant held until ddr_rdone or timeout.
module ddr_rd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16,
    parameter int DQ_WIDTH   = 32,
    parameter int TIMEOUT    = 4096
) (
    input  logic                             ddr_clk,
    input  logic                             ddr_rst,
    input  logic [CH_NUM-1:0]                ch_rreq,
    input  logic [CH_NUM*ADDR_WIDTH-1:0]     ch_raddr,
    input  logic [CH_NUM*LEN_WIDTH-1:0]      ch_rd_len,
    output logic [CH_NUM-1:0]                ch_rdone,
    output logic [CH_NUM-1:0]                ch_rdata_en,
    output logic [8*DQ_WIDTH-1:0]            ch_rdata,
    output logic                             ddr_rreq,
    output logic [ADDR_WIDTH-1:0]            ddr_raddr,
    output logic [LEN_WIDTH-1:0]             ddr_rd_len,
    input  logic                             ddr_rrdy,
    input  logic                             ddr_rdone,
    input  logic [8*DQ_WIDTH-1:0]            ddr_rdata,
    input  logic                             ddr_rdata_en,
    output logic [ch_idx_w(CH_NUM)-1:0]      grant_id,
    output logic                             busy,
    output logic                             timeout_err,
    output logic                             stray_err
);

    localparam int CH_IDX_W = ch_idx_w(CH_NUM);
    localparam int CNT_W    = tmo_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t             state;
    logic [CH_IDX_W-1:0]    ptr;
    logic [CNT_W-1:0]       tmo_cnt;

    logic                   pick_vld;
    logic [CH_IDX_W-1:0]    pick_id;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [LEN_WIDTH-1:0]   win_len;
    logic                   in_data;
    logic                   tmo_hit;

    rr_pick #(
        .N (CH_NUM),
        .W (CH_IDX_W)
    ) u_rr_pick (
        .req    (ch_rreq),
        .ptr    (ptr),
        .vld    (pick_vld),
        .winner (pick_id)
    );

    assign win_addr = ch_raddr[pick_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len  = ch_rd_len[pick_id*LEN_WIDTH +: LEN_WIDTH];
    assign in_data  = (state == ST_DATA);
    assign tmo_hit  = ((state == ST_REQ) || (state == ST_DATA)) && (tmo_cnt == TMO_LAST);
    assign busy     = (state != ST_IDLE);
    assign ch_rdata = ddr_rdata;

    // Done pulses come from three sources: normal completion, forced release,
    // and zero-length requests retired straight out of IDLE.
    always_comb begin
        ch_rdata_en = '0;
        ch_rdone    = '0;
        if (in_data && ddr_rdata_en) begin
            ch_rdata_en[grant_id] = 1'b1;
        end
        if ((in_data && ddr_rdone) || tmo_hit) begin
            ch_rdone[grant_id] = 1'b1;
        end
        if ((state == ST_IDLE) && pick_vld && (win_len == '0)) begin
            ch_rdone[pick_id] = 1'b1;
        end
    end

    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            state       <= ST_IDLE;
            ptr         <= CH_IDX_W'(CH_NUM - 1);
            grant_id    <= '0;
            ddr_rreq    <= 1'b0;
            ddr_raddr   <= '0;
            ddr_rd_len  <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
            stray_err   <= 1'b0;
        end else begin
            if (!in_data && (ddr_rdata_en || ddr_rdone)) begin
                stray_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_id   <= pick_id;
                        ptr        <= pick_id;
                        ddr_raddr  <= win_addr;
                        ddr_rd_len <= win_len;
                        if (win_len == '0) begin
                            state <= ST_GAP;
                        end else begin
                            state    <= ST_REQ;
                            ddr_rreq <= 1'b1;
                            tmo_cnt  <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        ddr_rreq    <= 1'b0;
                        state       <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (ddr_rrdy) begin
                            ddr_rreq <= 1'b0;
                            state    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (ddr_rdone) begin
                        state <= ST_GAP;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Bench for ddr_rd_arbiter: per-cycle reference model plus directed scenarios.
module tb_ddr_rd_arbiter;

    localparam int CH  = 4;
    localparam int AW  = 27;
    localparam int LW  = 16;
    localparam int DQ  = 32;
    localparam int DW  = 8 * DQ;
    // Long enough for a 60-beat burst; the timeout scenario uses this value.
    localparam int TMO = 128;

    logic              ddr_clk = 1'b0;
    logic              ddr_rst = 1'b1;
    logic [CH-1:0]     ch_rreq = '0;
    logic [CH*AW-1:0]  ch_raddr = '0;
    logic [CH*LW-1:0]  ch_rd_len = '0;
    logic [CH-1:0]     ch_rdone;
    logic [CH-1:0]     ch_rdata_en;
    logic [DW-1:0]     ch_rdata;
    logic              ddr_rreq;
    logic [AW-1:0]     ddr_raddr;
    logic [LW-1:0]     ddr_rd_len;
    logic              ddr_rrdy = 1'b0;
    logic              ddr_rdone = 1'b0;
    logic [DW-1:0]     ddr_rdata = '0;
    logic              ddr_rdata_en = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;
    logic              stray_err;

    ddr_rd_arbiter #(
        .CH_NUM(CH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DQ_WIDTH(DQ), .TIMEOUT(TMO)
    ) dut (
        .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
        .ch_rreq(ch_rreq), .ch_raddr(ch_raddr), .ch_rd_len(ch_rd_len),
        .ch_rdone(ch_rdone), .ch_rdata_en(ch_rdata_en), .ch_rdata(ch_rdata),
        .ddr_rreq(ddr_rreq), .ddr_raddr(ddr_raddr), .ddr_rd_len(ddr_rd_len),
        .ddr_rrdy(ddr_rrdy), .ddr_rdone(ddr_rdone), .ddr_rdata(ddr_rdata),
        .ddr_rdata_en(ddr_rdata_en), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .stray_err(stray_err)
    );

    always #5 ddr_clk = ~ddr_clk;

    int cyc = 0;
    always @(posedge ddr_clk) cyc++;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [LW-1:0] len_of(input int c);
        return ch_rd_len[c*LW +: LW];
    endfunction

    function automatic logic [AW-1:0] addr_of(input int c);
        return ch_raddr[c*AW +: AW];
    endfunction

    // Next requester after 'last' going upward with wrap, -1 if nobody asks.
    function automatic int rr_next(input logic [CH-1:0] req, input int last);
        for (int k = 1; k <= CH; k++) begin
            if (req[(last + k) % CH]) return (last + k) % CH;
        end
        return -1;
    endfunction

    // ---------------- reference model ----------------
    int          m_owner = -1;  // channel whose burst is in flight, -1 if none
    bit          m_acc   = 0;   // controller has accepted the in-flight request
    bit          m_cool  = 0;   // in the one-cycle pause after a grant ends
    int          m_age   = 0;   // cycles since the request was first raised
    int          m_last  = CH - 1;
    int          m_grant = 0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_len  = '0;
    bit          m_tmo   = 0;
    bit          m_stray = 0;

    always @(negedge ddr_clk) begin : model
        logic [CH-1:0] e_rdone, e_en;
        bit in_data, tmo_now, idle;
        int w;
        if (ddr_rst) begin
            m_owner = -1; m_acc = 0; m_cool = 0; m_age = 0; m_last = CH - 1;
            m_grant = 0; m_addr = '0; m_len = '0; m_tmo = 0; m_stray = 0;
        end
        in_data = (m_owner >= 0) && m_acc;
        tmo_now = (m_owner >= 0) && (m_age == TMO - 1);
        idle    = (m_owner < 0) && !m_cool;
        w       = rr_next(ch_rreq, m_last);
        e_en    = '0;
        e_rdone = '0;
        if (in_data && ddr_rdata_en) e_en[m_owner] = 1'b1;
        if ((in_data && ddr_rdone) || tmo_now) e_rdone[m_owner] = 1'b1;
        if (idle && w >= 0 && len_of(w) == 0) e_rdone[w] = 1'b1;

        chk("busy", busy, (m_owner >= 0) || m_cool);
        chk("ddr_rreq", ddr_rreq, (m_owner >= 0) && !m_acc);
        chk("grant_id", grant_id, m_grant);
        chk("ddr_raddr", ddr_raddr, m_addr);
        chk("ddr_rd_len", ddr_rd_len, m_len);
        chk("timeout_err", timeout_err, m_tmo);
        chk("stray_err", stray_err, m_stray);
        chk("ch_rdone", ch_rdone, e_rdone);
        chk("ch_rdata_en", ch_rdata_en, e_en);
        chk("ch_rdata", ch_rdata, ddr_rdata);

        if (!ddr_rst) begin
            if (!in_data && (ddr_rdata_en || ddr_rdone)) m_stray = 1;
            if (m_cool) begin
                m_cool = 0;
            end else if (m_owner < 0) begin
                if (w >= 0) begin
                    m_last = w; m_grant = w; m_addr = addr_of(w); m_len = len_of(w);
                    if (m_len == 0) m_cool = 1;
                    else begin m_owner = w; m_acc = 0; m_age = 0; end
                end
            end else if (in_data && ddr_rdone) begin
                m_owner = -1; m_cool = 1;
            end else if (tmo_now) begin
                m_tmo = 1; m_owner = -1; m_cool = 1;
            end else begin
                if (!m_acc && ddr_rrdy) m_acc = 1;
                m_age++;
            end
        end
    end

    // ---------------- event monitor ----------------
    int grants[$];
    int gaps[$];
    int n_rdone[CH];
    int n_en[CH];
    int rdone_cyc[CH];
    int n_rreq_hi, rreq_first, rreq_last, n_busy, tmo_cyc, last_rdone;
    bit prev_busy = 0, prev_rreq = 0;

    task automatic clr_mon();
        grants.delete(); gaps.delete();
        for (int c = 0; c < CH; c++) begin n_rdone[c] = 0; n_en[c] = 0; rdone_cyc[c] = -1; end
        n_rreq_hi = 0; rreq_first = -1; rreq_last = -1; n_busy = 0; tmo_cyc = -1; last_rdone = -1;
    endtask

    always @(negedge ddr_clk) begin
        if (busy && !prev_busy) grants.push_back(int'(grant_id));
        if (ddr_rreq && !prev_rreq) begin
            if (rreq_first < 0) rreq_first = cyc;
            if (last_rdone >= 0) gaps.push_back(cyc - last_rdone);
        end
        if (ddr_rreq) begin n_rreq_hi++; rreq_last = cyc; end
        if (busy) n_busy++;
        if (timeout_err && tmo_cyc < 0) tmo_cyc = cyc;
        for (int c = 0; c < CH; c++) begin
            if (ch_rdone[c]) begin n_rdone[c]++; rdone_cyc[c] = cyc; last_rdone = cyc; end
            if (ch_rdata_en[c]) n_en[c]++;
        end
        prev_busy = busy;
        prev_rreq = ddr_rreq;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(posedge ddr_clk); #1; end
    endtask

    task automatic set_ch(input int c, input logic [AW-1:0] a, input logic [LW-1:0] l);
        ch_raddr[c*AW +: AW] = a;
        ch_rd_len[c*LW +: LW] = l;
    endtask

    task automatic rnd_data();
        for (int i = 0; i < 8; i++) ddr_rdata[i*32 +: 32] = $urandom;
    endtask

    // Controller: wait for a request, accept after 'wt' cycles, send beats, optionally finish.
    task automatic serve(input int wt, input int beats, input bit done);
        int b = 0;
        while (!ddr_rreq && b < 60) begin tick(1); b++; end
        chk("serve_wait_rreq", ddr_rreq, 1'b1);
        if (!ddr_rreq) return;
        tick(wt);
        ddr_rrdy = 1'b1; tick(1); ddr_rrdy = 1'b0;
        for (int i = 0; i < beats; i++) begin
            ddr_rdata_en = 1'b1; rnd_data(); tick(1);
        end
        ddr_rdata_en = 1'b0;
        if (done) begin ddr_rdone = 1'b1; tick(1); ddr_rdone = 1'b0; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by 200000 ns, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int t, e, b;
        clr_mon();
        for (int c = 0; c < CH; c++) set_ch(c, AW'(32'h0100000 * (c + 1)), LW'(4 + c));
        tick(3);
        chk("rst_ddr_rreq", ddr_rreq, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_ddr_raddr", ddr_raddr, '0);
        chk("rst_errs", {timeout_err, stray_err}, 2'b00);
        ddr_rst = 1'b0;

        // All four requesting continuously.
        ch_rreq = 4'b1111;
        for (int k = 0; k < 6; k++) serve(1, 4, 1'b1);
        ch_rreq = '0;
        tick(3);
        chk("rr_grant_cnt", grants.size(), 6);
        for (int k = 0; k < 6 && k < grants.size(); k++) chk("rr_order", grants[k], k % 4);
        chk("rr_gap_cnt", gaps.size(), 5);
        foreach (gaps[k]) chk("rr_gap_len", gaps[k], 3);

        // Single channel, 60 beats, accept three cycles after the request.
        clr_mon();
        set_ch(1, 27'h0001000, 16'd60);
        t = cyc;
        ch_rreq = 4'b0010;
        serve(3, 60, 1'b1);
        ch_rreq = '0;
        tick(3);
        chk("s1_rreq_first", rreq_first, t + 1);
        chk("s1_rreq_last", rreq_last, t + 4);
        chk("s1_rreq_cycles", n_rreq_hi, 4);
        chk("s1_raddr", ddr_raddr, 27'h0001000);
        chk("s1_len", ddr_rd_len, 16'd60);
        chk("s1_grant", grant_id, 2'd1);
        chk("s1_en_beats", n_en[1], 60);
        chk("s1_rdone_cnt", n_rdone[1], 1);

        // Zero-length request retires without touching DDR.
        clr_mon();
        set_ch(2, 27'h0003000, 16'd0);
        t = cyc;
        ch_rreq = 4'b0100;
        tick(1);
        ch_rreq = '0;
        tick(3);
        chk("z_rdone_cyc", rdone_cyc[2], t);
        chk("z_rdone_cnt", n_rdone[2], 1);
        chk("z_no_rreq", n_rreq_hi, 0);
        chk("z_busy_cycles", n_busy, 1);
        chk("z_grant", grant_id, 2'd2);
        set_ch(2, 27'h0003000, 16'd7);

        // Controller never finishes: forced release.
        clr_mon();
        set_ch(0, 27'h0004000, 16'd8);
        ch_rreq = 4'b0001;
        serve(1, 2, 1'b0);
        e = rreq_first;
        b = 0;
        while (n_rdone[0] == 0 && b < TMO + 10) begin tick(1); b++; end
        ch_rreq = '0;
        tick(2);
        chk("t_rdone_cyc", rdone_cyc[0], e + TMO - 1);
        chk("t_err_cyc", tmo_cyc, e + TMO);
        chk("t_rdone_cnt", n_rdone[0], 1);
        ch_rreq = 4'b1000;
        serve(0, 3, 1'b1);
        ch_rreq = '0;
        tick(2);
        chk("t_next_grant", grant_id, 2'd3);
        chk("t_next_done", n_rdone[3], 1);
        chk("t_err_sticky", timeout_err, 1'b1);

        // Stray data strobe while idle.
        clr_mon();
        ddr_rdata_en = 1'b1; tick(1); ddr_rdata_en = 1'b0;
        tick(1);
        chk("st_err", stray_err, 1'b1);
        chk("st_no_fwd", n_en[0] + n_en[1] + n_en[2] + n_en[3], 0);
        tick(5);
        chk("st_sticky", stray_err, 1'b1);

        // Asynchronous reset in the middle of a burst.
        ch_rreq = 4'b0010;
        b = 0;
        while (!ddr_rreq && b < 20) begin tick(1); b++; end
        ddr_rrdy = 1'b1; tick(1); ddr_rrdy = 1'b0;
        ddr_rdata_en = 1'b1; rnd_data(); tick(2);
        chk("ar_pre_en", ch_rdata_en, 4'b0010);
        ch_rreq = 4'b0111;
        #2 ddr_rst = 1'b1;
        #1;
        chk("ar_rreq", ddr_rreq, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_en", ch_rdata_en, 4'b0000);
        chk("ar_errs", {timeout_err, stray_err}, 2'b00);
        ddr_rdata_en = 1'b0;
        tick(2);
        clr_mon();
        ddr_rst = 1'b0;
        serve(0, 2, 1'b1);
        ch_rreq = '0;
        tick(3);
        chk("ar_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
